// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU command sequencer
package alu_pkg;

   localparam logic MODE_ARITH = 1'b1;
   localparam logic MODE_LOGIC = 1'b0;

   // Arithmetic ops (mode = 1)
   localparam logic [1:0] ADD  = 2'b00;
   localparam logic [1:0] SUB  = 2'b01;
   localparam logic [1:0] DIV  = 2'b10;
   localparam logic [1:0] MUL  = 2'b11;

   // Logic ops (mode = 0)
   localparam logic [1:0] LAND = 2'b00;
   localparam logic [1:0] LOR  = 2'b01;
   localparam logic [1:0] LXOR = 2'b10;
   localparam logic [1:0] LNOT = 2'b11;

   // One queued command: 1 + 2 + 8 + 8 = 19 bits
   typedef struct packed {
      logic       mode;
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
   } alu_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } seq_state_t;

   // The only case the sequencer overrides the ALU result
   function automatic logic is_div_by_zero(input logic       mode,
                                           input logic [1:0] op,
                                           input logic [7:0] b);
      return (mode == MODE_ARITH) && (op == DIV) && (b == 8'd0);
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO, DEPTH x alu_cmd_t
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  alu_cmd_t                 push_data,
   input  logic                     pop,
   output alu_cmd_t                 pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   alu_cmd_t        mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic            push_en;
   logic            pop_en;

   // Overflow and underflow attempts are ignored rather than corrupting state
   assign push_en  = push && !full;
   assign pop_en   = pop && !empty;
   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   // Pointers wrap naturally at DEPTH (power of 2); count tracks occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_en, pop_en})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - queues ALU commands, drives the ALU, returns results
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_mode,
   input  logic [1:0]  cmd_op,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic        alu_mode,
   output logic [1:0]  alu_op,
   input  logic [7:0]  alu_f,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_data,
   output logic        rsp_dbz,
   output logic        busy
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   seq_state_t       state_q;
   logic [SW-1:0]    settle_q;
   logic [7:0]       alu_a_q;
   logic [7:0]       alu_b_q;
   logic             alu_mode_q;
   logic [1:0]       alu_op_q;
   logic [7:0]       rsp_data_q;
   logic             rsp_dbz_q;
   logic             rsp_valid_q;

   alu_cmd_t         push_cmd;
   alu_cmd_t         head_cmd;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;

   // Ready is withheld when full even if the engine pops this cycle
   assign cmd_ready = !rst && !fifo_full;
   assign fifo_push = cmd_valid && cmd_ready;
   assign push_cmd  = '{mode: cmd_mode, op: cmd_op, a: cmd_a, b: cmd_b};
   assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

   alu_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (push_cmd),
      .pop       (fifo_pop),
      .pop_data  (head_cmd),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Issue / settle / hand-off engine; alu_* only change on a pop
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         settle_q    <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_mode_q  <= 1'b0;
         alu_op_q    <= '0;
         rsp_data_q  <= '0;
         rsp_dbz_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  alu_a_q    <= head_cmd.a;
                  alu_b_q    <= head_cmd.b;
                  alu_mode_q <= head_cmd.mode;
                  alu_op_q   <= head_cmd.op;
                  settle_q   <= SW'(SETTLE - 1);
                  state_q    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (settle_q == '0) begin
                  if (is_div_by_zero(alu_mode_q, alu_op_q, alu_b_q)) begin
                     rsp_data_q <= 8'hFF;
                     rsp_dbz_q  <= 1'b1;
                  end else begin
                     rsp_data_q <= alu_f;
                     rsp_dbz_q  <= 1'b0;
                  end
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_HOLD;
               end else begin
                  settle_q <= settle_q - SW'(1);
               end
            end
            ST_HOLD: begin
               // Always return through IDLE so back-to-back commands get a gap cycle
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_mode  = alu_mode_q;
   assign alu_op    = alu_op_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_dbz   = rsp_dbz_q;
   assign rsp_valid = rsp_valid_q;
   assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule
